// File: rtl/tmds_timing_recover.sv
// tmds_timing_recover: rebuilds H/V timing, active window, pixel/line counts and segment index from decoded TMDS syncs.
// Define TIMING_MEASURE_EN to build the line-period / frame-length capture registers (meas_htotal, meas_vtotal).
module tmds_timing_recover #(
  parameter int CW          = 11,
  parameter int IW          = 12,
  parameter int H_TOTAL     = 1650,
  parameter int H_ACT_START = 220,
  parameter int H_ACT_LEN   = 1280,
  parameter int V_ACT_START = 21,
  parameter int V_ACT_LEN   = 720,
  parameter int HS_QUAL     = 40,
  parameter int SEG_LEN     = 640,
  parameter int LOCK_LINES  = 4
) (
  input  logic          rx0_pclk,
  input  logic          rstbtn_n,
  input  logic          rx0_hsync,
  input  logic          rx0_vsync,
  output logic          video_en,
  output logic [CW-1:0] hcounter,
  output logic [CW-1:0] vcounter,
  output logic [CW-1:0] video_hcnt,
  output logic [CW-1:0] video_vcnt,
  output logic [IW-1:0] index,
  output logic          locked,
  output logic [15:0]   meas_htotal,
  output logic [CW-1:0] meas_vtotal
);

  localparam int QW   = $clog2(HS_QUAL + 1);
  localparam int LW   = 16;
  localparam int MW   = $clog2(LOCK_LINES + 1);
  localparam int NSEG = H_ACT_LEN / SEG_LEN;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ON    = CW'(H_ACT_START);
  localparam logic [CW-1:0] H_OFF   = CW'(H_ACT_START + H_ACT_LEN);
  localparam logic [CW-1:0] V_ON    = CW'(V_ACT_START);
  localparam logic [CW-1:0] V_OFF   = CW'(V_ACT_START + V_ACT_LEN);
  localparam logic [QW-1:0] Q_FIRE  = QW'(HS_QUAL - 1);
  localparam logic [QW-1:0] Q_MAX   = QW'(HS_QUAL);
  localparam logic [LW-1:0] LEN_MAX = LW'(2 * H_TOTAL);
  localparam logic [LW-1:0] LEN_OK  = LW'(H_TOTAL - 1);
  localparam logic [MW-1:0] M_LAST  = MW'(LOCK_LINES - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  logic              vs_d;
  logic              vs_rise;
  logic [QW-1:0]     hs_run;
  logic              hs_q;
  logic              hactive;
  logic              vactive;
  logic [LW-1:0]     llen;
  logic              llen_to;
  logic              period_ok;
  logic [MW-1:0]     mcnt;
  lock_state_t       state;

  function automatic logic [QW-1:0] run_sat_inc(input logic [QW-1:0] v);
    return (v == Q_MAX) ? v : v + QW'(1);
  endfunction

  function automatic logic [LW-1:0] len_sat_inc(input logic [LW-1:0] v);
    return (v == LEN_MAX) ? v : v + LW'(1);
  endfunction

  function automatic logic seg_start(input logic [CW-1:0] hc);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NSEG; k++) begin
      if (hc == CW'(H_ACT_START + k * SEG_LEN)) hit = 1'b1;
    end
    return hit;
  endfunction

  // A qualified hsync fires once, on the HS_QUAL-th consecutive high cycle; shorter pulses never reach it.
  assign vs_rise   = rx0_vsync & ~vs_d;
  assign hs_q      = rx0_hsync && (hs_run == Q_FIRE);
  assign video_en  = hactive & vactive;
  assign llen_to   = (llen == LEN_MAX);
  assign period_ok = (llen == LEN_OK);

  always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      vs_d       <= 1'b0;
      hs_run     <= '0;
      llen       <= '0;
      hcounter   <= '0;
      vcounter   <= '0;
      hactive    <= 1'b0;
      vactive    <= 1'b0;
      video_hcnt <= '0;
      video_vcnt <= '0;
      index      <= '0;
    end else begin
      vs_d   <= rx0_vsync;
      hs_run <= rx0_hsync ? run_sat_inc(hs_run) : '0;
      llen   <= hs_q ? '0 : len_sat_inc(llen);

      if (hs_q || (hcounter == H_LAST)) hcounter <= '0;
      else                              hcounter <= hcounter + CW'(1);

      if (vs_rise)   vcounter <= '0;
      else if (hs_q) vcounter <= vcounter + CW'(1);

      if (hcounter == H_ON)       hactive <= 1'b1;
      else if (hcounter == H_OFF) hactive <= 1'b0;

      if (vcounter == V_ON)       vactive <= 1'b1;
      else if (vcounter == V_OFF) vactive <= 1'b0;

      video_hcnt <= video_en ? video_hcnt + CW'(1) : '0;

      if (!vactive)  video_vcnt <= '0;
      else if (hs_q) video_vcnt <= video_vcnt + CW'(1);

      if (vs_rise)                               index <= '0;
      else if (vactive && seg_start(hcounter))   index <= index + IW'(1);
    end
  end

  // Missing hsync (llen saturated) always drops back to SEARCH, ahead of any hs_q in the same cycle.
  always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      state  <= SEARCH;
      mcnt   <= '0;
      locked <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (hs_q) begin
            state <= TRACK;
            mcnt  <= '0;
          end
        end
        TRACK: begin
          if (llen_to) begin
            state <= SEARCH;
            mcnt  <= '0;
          end else if (hs_q) begin
            if (!period_ok) begin
              mcnt <= '0;
            end else if (mcnt == M_LAST) begin
              state  <= LOCKED;
              mcnt   <= '0;
              locked <= 1'b1;
            end else begin
              mcnt <= mcnt + MW'(1);
            end
          end
        end
        LOCKED: begin
          if (llen_to) begin
            state  <= SEARCH;
            mcnt   <= '0;
            locked <= 1'b0;
          end else if (hs_q && !period_ok) begin
            state  <= TRACK;
            mcnt   <= '0;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          mcnt   <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef TIMING_MEASURE_EN
  always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      meas_htotal <= '0;
      meas_vtotal <= '0;
    end else begin
      if (hs_q)    meas_htotal <= llen + 16'd1;
      if (vs_rise) meas_vtotal <= vcounter + CW'(1);
    end
  end
`else
  assign meas_htotal = '0;
  assign meas_vtotal = '0;
`endif

endmodule

// File: tb/tb_tmds_timing_recover.sv
// Directed bench for tmds_timing_recover on a scaled-down raster (60x30, 40x20 active) to keep runs short.
module tb_tmds_timing_recover;

  localparam int CW  = 11;
  localparam int IW  = 12;
  localparam int HT  = 60;
  localparam int HAS = 10;
  localparam int HAL = 40;
  localparam int VAS = 4;
  localparam int VAL = 20;
  localparam int HQ  = 6;
  localparam int SEG = 20;
  localparam int LL  = 4;
  localparam int VT  = 30;

  logic          rx0_pclk = 1'b0;
  logic          rstbtn_n = 1'b0;
  logic          rx0_hsync = 1'b0;
  logic          rx0_vsync = 1'b0;
  logic          video_en;
  logic [CW-1:0] hcounter;
  logic [CW-1:0] vcounter;
  logic [CW-1:0] video_hcnt;
  logic [CW-1:0] video_vcnt;
  logic [IW-1:0] index;
  logic          locked;
  logic [15:0]   meas_htotal;
  logic [CW-1:0] meas_vtotal;

  always #5 rx0_pclk = ~rx0_pclk;

  tmds_timing_recover #(
    .CW(CW), .IW(IW), .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT_LEN(HAL),
    .V_ACT_START(VAS), .V_ACT_LEN(VAL), .HS_QUAL(HQ), .SEG_LEN(SEG), .LOCK_LINES(LL)
  ) dut (
    .rx0_pclk(rx0_pclk), .rstbtn_n(rstbtn_n), .rx0_hsync(rx0_hsync), .rx0_vsync(rx0_vsync),
    .video_en(video_en), .hcounter(hcounter), .vcounter(vcounter),
    .video_hcnt(video_hcnt), .video_vcnt(video_vcnt), .index(index), .locked(locked),
    .meas_htotal(meas_htotal), .meas_vtotal(meas_vtotal)
  );

  int n_run  = 0;
  int n_fail = 0;

  int   ven, hc_max, vc_max, lock_bad;
  logic lk_q;
  int   vc_q, ix_q, mh_q, mv_q, hc_probe, vc_probe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pix(input logic h, input logic v);
    rx0_hsync = h;
    rx0_vsync = v;
    @(posedge rx0_pclk);
    #1;
  endtask

  // One line: hsync high for the first HQ cycles, optional short glitch, vsync rising with the qualified hsync.
  task automatic run_line(input int len, input bit vs_line, input int glitch_at);
    logic h, v;
    for (int c = 0; c < len; c++) begin
      h = (c < HQ) || (glitch_at >= 0 && c >= glitch_at && c < glitch_at + HQ - 1);
      v = vs_line && (c >= HQ - 1);
      pix(h, v);
      if (video_en) ven++;
      if (int'(video_hcnt) > hc_max) hc_max = int'(video_hcnt);
      if (int'(video_vcnt) > vc_max) vc_max = int'(video_vcnt);
      if (c == HQ - 1) begin
        lk_q = locked;
        vc_q = int'(vcounter);
        ix_q = int'(index);
        mh_q = int'(meas_htotal);
        mv_q = int'(meas_vtotal);
      end
      if (c == 40) begin
        hc_probe = int'(hcounter);
        vc_probe = int'(vcounter);
      end
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_video_en"},   32'(video_en),   0);
    chk({pfx, "_hcounter"},   32'(hcounter),   0);
    chk({pfx, "_vcounter"},   32'(vcounter),   0);
    chk({pfx, "_video_hcnt"}, 32'(video_hcnt), 0);
    chk({pfx, "_video_vcnt"}, 32'(video_vcnt), 0);
    chk({pfx, "_index"},      32'(index),      0);
    chk({pfx, "_locked"},     32'(locked),     0);
    chk({pfx, "_meas_h"},     32'(meas_htotal), 0);
    chk({pfx, "_meas_v"},     32'(meas_vtotal), 0);
  endtask

  initial begin
    lock_bad = 0;
    ven = 0; hc_max = 0; vc_max = 0;
    repeat (3) pix(1'b0, 1'b0);
    chk_all_zero("reset");
    rstbtn_n = 1'b1;

    for (int f = 1; f <= 3; f++) begin
      ven = 0; hc_max = 0; vc_max = 0;
      for (int l = 0; l < VT; l++) begin
        run_line(HT, l == 0, -1);
        if (l == 0) begin
          chk($sformatf("f%0d_vcnt_at_vsync", f), 32'(vc_q), 0);
          chk($sformatf("f%0d_index_at_vsync", f), 32'(ix_q), 0);
`ifdef TIMING_MEASURE_EN
          if (f == 1) chk("meas_vtotal_empty_frame", 32'(mv_q), 1);
          if (f == 3) begin
            chk("meas_htotal", 32'(mh_q), HT);
            chk("meas_vtotal", 32'(mv_q), VT);
          end
`else
          if (f == 3) begin
            chk("meas_htotal_off", 32'(mh_q), 0);
            chk("meas_vtotal_off", 32'(mv_q), 0);
          end
`endif
        end
        if (lk_q !== (((f - 1) * VT + l) >= LL)) lock_bad++;
        if (f == 1 && l == LL - 1) chk("lock_before_4th_period", 32'(lk_q), 0);
        if (f == 1 && l == LL)     chk("lock_rise", 32'(lk_q), 1);
      end
      chk($sformatf("f%0d_video_en_cycles", f), 32'(ven), HAL * VAL);
      chk($sformatf("f%0d_hcnt_peak", f), 32'(hc_max), HAL);
      chk($sformatf("f%0d_vcnt_peak", f), 32'(vc_max), VAL);
      chk($sformatf("f%0d_index_end", f), 32'(index), 2 * VAL);
    end
    chk("lock_hold_errors", 32'(lock_bad), 0);

    // Frame 4: one long line (period HT+2) and a sub-threshold hsync glitch.
    for (int l = 0; l < 12; l++) begin
      run_line((l == 2) ? HT + 2 : HT, l == 0, (l == 10) ? 30 : -1);
      if (l == 0) begin
        chk("f4_vcnt_at_vsync", 32'(vc_q), 0);
        chk("f4_index_at_vsync", 32'(ix_q), 0);
      end
      if (l == 3) begin
        chk("lock_drop_long_line", 32'(lk_q), 0);
`ifdef TIMING_MEASURE_EN
        chk("meas_htotal_long", 32'(mh_q), HT + 2);
`endif
      end
      if (l == 6) chk("lock_still_tracking", 32'(lk_q), 0);
      if (l == 7) chk("lock_rerise", 32'(lk_q), 1);
      if (l == 10) begin
        chk("glitch_hcounter", 32'(hc_probe), 35);
        chk("glitch_vcounter", 32'(vc_probe), 10);
        chk("glitch_lock", 32'(locked), 1);
      end
    end

    // Remove hsync: line 11's qualified hsync was the last; 2*HT cycles later llen saturates.
    repeat (HT + HQ) pix(1'b0, 1'b0);
    chk("lock_before_timeout", 32'(locked), 1);
    pix(1'b0, 1'b0);
    chk("lock_after_timeout", 32'(locked), 0);

    // Frame 5: relock from SEARCH, then an asynchronous reset mid active line.
    for (int l = 0; l < 6; l++) begin
      run_line(HT, l == 0, -1);
      if (l == LL - 1) chk("relock_before", 32'(lk_q), 0);
      if (l == LL)     chk("relock_rise", 32'(lk_q), 1);
    end
    run_line(30, 1'b0, -1);
    chk("pre_reset_video_en", 32'(video_en), 1);
    chk("pre_reset_vcounter", 32'(vcounter), 6);
    #3;
    rstbtn_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #2;
    rstbtn_n = 1'b1;
    pix(1'b0, 1'b0);
    chk("resume_hcounter", 32'(hcounter), 1);
    chk("resume_vcounter", 32'(vcounter), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
